// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and defaults for the instruction fetch unit
package ifetch_pkg;
  localparam int DATA_W = 32;
  localparam int PC_W = 64;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam logic [63:0] DEF_FETCH_LIMIT = 64'hF8;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0] pc;
    logic fault;
  } entry_t;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: memory port, decode handshake and redirect bundle of the fetch unit
interface ifetch_if;
  import ifetch_pkg::*;
  logic [PC_W-1:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic inst_valid;
  logic inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [PC_W-1:0] inst_pc;
  logic inst_fault;
  logic redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  modport master (
    output HADDR, HWDATA, inst_valid, inst_data, inst_pc, inst_fault,
    input HRDATA, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input HADDR, HWDATA, inst_valid, inst_data, inst_pc, inst_fault,
    output HRDATA, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: circular instruction buffer, up to two pushes and one pop per cycle
module ifetch_fifo import ifetch_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic push0_i,
  input  logic push1_i,
  input  logic pop_i,
  input  entry_t d0_i,
  input  entry_t d1_i,
  output entry_t head_o,
  output logic [AW:0] count_o
);
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, n_push, n_pop;
  // push1 always lands in the slot right after push0
  always_comb begin
    n_push = (AW+1)'(push0_i) + (AW+1)'(push1_i);
    n_pop = (AW+1)'(pop_i);
    head_o = cnt_q != '0 ? mem_q[rd_q] : '0;
    count_o = cnt_q;
  end
  // storage writes, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_q] <= d0_i;
    if (push1_i) mem_q[wr_q + AW'(1)] <= d1_i;
  end
  // pointers and occupancy; flush drops everything including a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + n_push[AW-1:0];
      rd_q <= rd_q + n_pop[AW-1:0];
      cnt_q <= cnt_q + n_push - n_pop;
    end
  end
endmodule

// File: rtl/ifetch.sv
// ifetch: 64-bit-wide instruction fetch into a small buffer with redirect and range fault
module ifetch import ifetch_pkg::*; #(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter logic [63:0] FETCH_LIMIT = DEF_FETCH_LIMIT,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ifetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [63:0] pc_q, pc_d, haddr;
  logic [CW-1:0] cnt, free;
  logic due, flt, fetch, push0, push1, pop;
  entry_t d0, d1, head;
  // fetch decision: slots are counted before any same-cycle pop
  always_comb begin
    haddr = {pc_q[63:3], 3'b000};
    free = CW'(FIFO_DEPTH) - cnt;
    due = state_q == RUN && !bus.redirect_valid && free >= (pc_q[2] ? CW'(1) : CW'(2));
    flt = due && haddr >= FETCH_LIMIT;
    fetch = due && !flt;
    push0 = due;
    push1 = fetch && !pc_q[2];
    d0.data = flt ? '0 : pc_q[2] ? bus.HRDATA[63:32] : bus.HRDATA[31:0];
    d0.pc = pc_q;
    d0.fault = flt;
    d1.data = bus.HRDATA[63:32];
    d1.pc = pc_q + 64'd4;
    d1.fault = 1'b0;
    pop = bus.inst_valid && bus.inst_ready;
  end
  // next state and next fetch address; redirect overrides everything
  always_comb begin
    state_d = bus.redirect_valid ? RUN : state_q == BOOT ? RUN : (state_q == RUN && flt) ? HALT : state_q;
    pc_d = bus.redirect_valid ? (bus.redirect_pc & ~64'h3) : fetch ? {pc_q[63:3] + 61'd1, 3'b000} : pc_q;
  end
  // state and fetch pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush_i(bus.redirect_valid),
    .push0_i(push0),
    .push1_i(push1),
    .pop_i(pop),
    .d0_i(d0),
    .d1_i(d1),
    .head_o(head),
    .count_o(cnt)
  );
  assign bus.HADDR = haddr;
  assign bus.HWDATA = '0;
  assign bus.inst_valid = cnt != '0;
  assign bus.inst_data = head.data;
  assign bus.inst_pc = head.pc;
  assign bus.inst_fault = head.fault;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: scoreboard bench for ifetch against a small ROM model
module tb_ifetch;
  import ifetch_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  entry_t exp_q[$];
  entry_t got, want;
  ifetch_if bus();
  ifetch #(.RESET_PC(64'h0), .FETCH_LIMIT(64'hF8), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] rom(input logic [63:0] a);
    return a == 64'h0 ? 64'h00108093_03003083 : {32'hC0DE0000 ^ (a[31:0] + 32'd4), 32'hC0DE0000 ^ a[31:0]};
  endfunction
  function automatic logic [31:0] exp_data(input logic [63:0] p);
    return p == 64'h0 ? 32'h03003083 : p == 64'h4 ? 32'h00108093 : 32'hC0DE0000 ^ p[31:0];
  endfunction
  assign bus.HRDATA = rom(bus.HADDR);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic push_seq(input logic [63:0] s, input logic [63:0] e);
    for (logic [63:0] p = s; p < e; p += 64'd4) exp_q.push_back('{exp_data(p), p, 1'b0});
  endtask
  task automatic wait_size(input int n, input int budget, input string name);
    int i = 0;
    while (exp_q.size() > n && i < budget) begin
      tick();
      i++;
    end
    check(name, 64'(exp_q.size()), 64'(n));
  endtask
  always @(negedge clk) begin
    if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
      checks++;
      got = '{bus.inst_data, bus.inst_pc, bus.inst_fault};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_entry got data=%h pc=%h fault=%b required none", got.data, got.pc, got.fault);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL entry got data=%h pc=%h fault=%b required data=%h pc=%h fault=%b",
                   got.data, got.pc, got.fault, want.data, want.pc, want.fault);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;
    tick();
    tick();
    check("rst_valid", 64'(bus.inst_valid), 64'h0);
    check("rst_haddr", bus.HADDR, 64'h0);
    check("rst_hwdata", bus.HWDATA, 64'h0);
    push_seq(64'h0, 64'h40);
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    tick();
    check("fetch_cycle_haddr", bus.HADDR, 64'h0);
    check("fetch_cycle_valid", 64'(bus.inst_valid), 64'h0);
    tick();
    check("first_valid", 64'(bus.inst_valid), 64'h1);
    check("first_pc", bus.inst_pc, 64'h0);
    check("first_data", 64'(bus.inst_data), 64'h03003083);
    wait_size(8, 50, "stream_drain");
    rst = 1'b1;
    bus.inst_ready = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_valid", 64'(bus.inst_valid), 64'h0);
    rst = 1'b0;
    push_seq(64'h0, 64'h40);
    repeat (8) tick();
    check("full_haddr", bus.HADDR, 64'h10);
    check("full_head_pc", bus.inst_pc, 64'h0);
    repeat (4) tick();
    check("full_haddr_held", bus.HADDR, 64'h10);
    check("full_valid", 64'(bus.inst_valid), 64'h1);
    bus.inst_ready = 1'b1;
    wait_size(8, 50, "release_drain");
    bus.inst_ready = 1'b0;
    repeat (6) tick();
    check("prefull_valid", 64'(bus.inst_valid), 64'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h1F;
    exp_q.delete();
    push_seq(64'h1C, 64'h5C);
    tick();
    bus.redirect_valid = 1'b0;
    check("redir_haddr", bus.HADDR, 64'h18);
    check("redir_flushed", 64'(bus.inst_valid), 64'h0);
    tick();
    check("redir_valid", 64'(bus.inst_valid), 64'h1);
    check("redir_pc", bus.inst_pc, 64'h1C);
    check("redir_data", 64'(bus.inst_data), 64'hC0DE001C);
    bus.inst_ready = 1'b1;
    wait_size(4, 60, "redir_drain");
    check("pre_pop_redir_valid", 64'(bus.inst_valid), 64'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h80;
    exp_q.delete();
    push_seq(64'h80, 64'hF8);
    exp_q.push_back('{32'h0, 64'hF8, 1'b1});
    tick();
    bus.redirect_valid = 1'b0;
    check("pop_redir_flushed", 64'(bus.inst_valid), 64'h0);
    tick();
    check("pop_redir_pc", bus.inst_pc, 64'h80);
    wait_size(0, 200, "fault_drain");
    repeat (10) tick();
    check("halt_valid", 64'(bus.inst_valid), 64'h0);
    check("halt_haddr", bus.HADDR, 64'hF8);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h0;
    exp_q.delete();
    push_seq(64'h0, 64'h40);
    tick();
    bus.redirect_valid = 1'b0;
    check("restart_haddr", bus.HADDR, 64'h0);
    tick();
    check("restart_pc", bus.inst_pc, 64'h0);
    wait_size(10, 50, "restart_drain");
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h4;
    exp_q.delete();
    tick();
    bus.redirect_valid = 1'b0;
    repeat (6) tick();
    check("odd_haddr", bus.HADDR, 64'h10);
    check("odd_pc", bus.inst_pc, 64'h4);
    check("odd_data", 64'(bus.inst_data), 64'h00108093);
    rst = 1'b1;
    tick();
    check("rst3_valid", 64'(bus.inst_valid), 64'h0);
    check("rst3_haddr", bus.HADDR, 64'h0);
    rst = 1'b0;
    push_seq(64'h0, 64'h40);
    bus.inst_ready = 1'b1;
    tick();
    tick();
    check("rst3_pc", bus.inst_pc, 64'h0);
    wait_size(12, 50, "final_drain");
    bus.inst_ready = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
